// File: rtl/muldiv_share_arbiter_if.sv
// Request/response bundle between NUM_CORES execute stages and the shared mul/div engine.
// Signal names keep the engine's i_/o_ port naming so the bundle reads like the original port list.
interface muldiv_share_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int DATA_SIZE = 32
);
  logic [NUM_CORES-1:0]           i_req;
  logic [2*NUM_CORES-1:0]         i_op;
  logic [DATA_SIZE*NUM_CORES-1:0] i_op_a;
  logic [DATA_SIZE*NUM_CORES-1:0] i_op_b;
  logic [NUM_CORES-1:0]           o_grant;
  logic [NUM_CORES-1:0]           o_done;
  logic [DATA_SIZE-1:0]           o_result;
  logic                           o_busy;

  modport master (
    output i_req, i_op, i_op_a, i_op_b,
    input  o_grant, o_done, o_result, o_busy
  );

  modport slave (
    input  i_req, i_op, i_op_a, i_op_b,
    output o_grant, o_done, o_result, o_busy
  );
endinterface

// File: rtl/muldiv_share_arbiter.sv
// One iterative 1-bit/cycle MUL/MULHU/DIVU/REMU engine shared round-robin by NUM_CORES requesters.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave CALC as soon as the remaining multiplier bits are zero.
module muldiv_share_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int DATA_SIZE = 32
) (
  input  logic                   i_aclk,
  input  logic                   i_areset_n,
  muldiv_share_arbiter_if.slave  bus
);

  localparam int N     = DATA_SIZE;
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_DONE} state_e;
  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, owner_q, owner_sel, win_idx, cand, ptr_after_owner;
  logic               win_found;
  logic [1:0]         win_op;
  logic [N-1:0]       win_a, win_b;

  op_e                op_q;
  logic [N-1:0]       a_q, b_q;
  logic [N-1:0]       mplier_q, mplier_d;
  logic [2*N-1:0]     acc_q, acc_d, mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [N:0]         rem_shift, rem_diff;
  logic [N-1:0]       result_d, result_q;

  logic               abort, is_div, div_by_zero, last_step;
  logic [NUM_CORES-1:0] grant_d, grant_q, done_d, done_q;
  logic               busy_d, busy_q;

  // Round-robin pick: first requester at or after the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NUM_CORES);
      if (!win_found && bus.i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_op = bus.i_op[int'(win_idx)*2 +: 2];
  assign win_a  = bus.i_op_a[int'(win_idx)*N +: N];
  assign win_b  = bus.i_op_b[int'(win_idx)*N +: N];

  assign ptr_after_owner = (owner_q == PTR_W'(NUM_CORES-1)) ? '0 : owner_q + PTR_W'(1);
  assign abort       = ((state_q == S_LOAD) || (state_q == S_CALC)) && !bus.i_req[owner_q];
  assign is_div      = op_q[1];
  assign div_by_zero = is_div && (b_q == '0);

  // One iteration step. Multiply: shift-add with the multiplicand walking left.
  // Divide: restoring step; mplier_q holds dividend bits shifting out and quotient bits shifting in.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can leave it unassigned and infer a latch.
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_shift = {acc_q[N-1:0], mplier_q[N-1]};
    rem_diff  = rem_shift - {1'b0, b_q};
    if (is_div) begin
      mplier_d = {mplier_q[N-2:0], ~rem_diff[N]};
      acc_d    = {{N{1'b0}}, (rem_diff[N] ? rem_shift[N-1:0] : rem_diff[N-1:0])};
    end else begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign last_step = (cnt_q == '0) || (!is_div && (mplier_d == '0));
`else
  assign last_step = (cnt_q == '0);
`endif

  always_comb begin
    result_d = acc_d[N-1:0];
    case (op_q)
      OP_MUL:   result_d = acc_d[N-1:0];
      OP_MULHU: result_d = acc_d[2*N-1:N];
      OP_DIVU:  result_d = div_by_zero ? {N{1'b1}} : mplier_d;
      OP_REMU:  result_d = div_by_zero ? a_q : acc_d[N-1:0];
      default:  result_d = acc_d[N-1:0];
    endcase
  end

  // FSM: state register
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (win_found) state_d = S_LOAD;
      S_LOAD: begin
        if (abort)            state_d = S_IDLE;
        else if (div_by_zero) state_d = S_DONE;
        else                  state_d = S_CALC;
      end
      S_CALC: begin
        if (abort)          state_d = S_IDLE;
        else if (last_step) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs, computed one cycle ahead and registered below
  always_comb begin
    grant_d   = '0;
    done_d    = '0;
    owner_sel = (state_q == S_IDLE) ? win_idx : owner_q;
    busy_d    = (state_d != S_IDLE);
    if (state_d != S_IDLE) grant_d[owner_sel] = 1'b1;
    if (state_d == S_DONE) done_d[owner_sel]  = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      result_q <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      case (state_q)
        S_IDLE: if (win_found) begin
          owner_q  <= win_idx;
          op_q     <= op_e'(win_op);
          a_q      <= win_a;
          b_q      <= win_b;
          acc_q    <= '0;
          mcand_q  <= {{N{1'b0}}, win_a};
          mplier_q <= win_op[1] ? win_a : win_b;
          cnt_q    <= CNT_W'(N-1);
        end
        S_CALC: if (!abort) begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
      if (state_d == S_DONE)                result_q <= result_d;
      if ((state_q == S_DONE) || abort)     ptr_q    <= ptr_after_owner;
    end
  end

  assign bus.o_grant  = grant_q;
  assign bus.o_done   = done_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_result = result_q;

endmodule

// File: tb/tb_muldiv_share_arbiter.sv
// Scoreboard bench for muldiv_share_arbiter: directed ops push expectations, a monitor checks each o_done.
module tb_muldiv_share_arbiter;
  localparam int NC = 4;
  localparam int DW = 32;
  localparam logic [1:0] MUL = 2'b00, MULHU = 2'b01, DIVU = 2'b10, REMU = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_share_arbiter_if #(.NUM_CORES(NC), .DATA_SIZE(DW)) bus ();

  muldiv_share_arbiter #(.NUM_CORES(NC), .DATA_SIZE(DW)) dut (
    .i_aclk     (clk),
    .i_areset_n (rst_n),
    .bus        (bus)
  );

  typedef struct {
    int          core;
    logic [31:0] res;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   load_cyc = 0;
  logic [NC-1:0] prev_grant = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycles from the LOAD cycle to the o_done cycle.
  function automatic int exp_gap(input logic [1:0] op, input logic [31:0] b);
    if (op[1] && b == 32'd0) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[1]) begin
      int m = 0;
      for (int i = 0; i < 32; i++) if (b[i]) m = i;
      return m + 2;
    end
`endif
    return DW + 1;
  endfunction

  task automatic sb_push(input int core, input logic [31:0] res, input int gap);
    exp_t e;
    e.core = core;
    e.res  = res;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic issue(input int core, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.i_op[core*2 +: 2]     = op;
    bus.i_op_a[core*DW +: DW] = a;
    bus.i_op_b[core*DW +: DW] = b;
    bus.i_req[core]           = 1'b1;
  endtask

  // Advance to the next falling edge; any core that got its done pulse drops its request.
  task automatic step_neg();
    @(negedge clk);
    bus.i_req = bus.i_req & ~bus.o_done;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(sb.size() == 0 && !bus.o_busy && bus.i_req == '0) && n < budget) begin
      step_neg();
      n++;
    end
    check("idle_reached", 64'(n < budget), 64'd1);
  endtask

  // Monitor: pops one expectation per done pulse and checks owner, value and latency.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_grant = '0;
    end else begin
      if (bus.o_grant != '0 && prev_grant == '0) load_cyc = cyc;
      prev_grant = bus.o_grant;
      if (bus.o_done != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(bus.o_done), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_owner", 64'(bus.o_done), 64'(1 << e.core));
          check("result", 64'(bus.o_result), 64'(e.res));
          check("latency", 64'(cyc - load_cyc), 64'(e.gap));
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    bus.i_req  = '0;
    bus.i_op   = '0;
    bus.i_op_a = '0;
    bus.i_op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", 64'(bus.o_grant), 64'd0);
    check("rst_done", 64'(bus.o_done), 64'd0);
    check("rst_result", 64'(bus.o_result), 64'd0);
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    rst_n = 1'b1;
    step_neg();

    // Core1 MUL 7*3, grant visible in the LOAD cycle
    sb_push(1, 32'h0000_0015, exp_gap(MUL, 32'd3));
    issue(1, MUL, 32'd7, 32'd3);
    step_neg();
    check("grant_load_c1", 64'(bus.o_grant), 64'b0010);
    wait_idle(100);

    // Core0 back-to-back DIVU, REMU, MULHU
    sb_push(0, 32'd14, exp_gap(DIVU, 32'd7));
    issue(0, DIVU, 32'd100, 32'd7);
    wait_idle(100);
    sb_push(0, 32'd2, exp_gap(REMU, 32'd7));
    issue(0, REMU, 32'd100, 32'd7);
    wait_idle(100);
    sb_push(0, 32'hFFFF_FFFE, exp_gap(MULHU, 32'hFFFF_FFFF));
    issue(0, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(100);

    // Divide by zero on core3: busy only in LOAD and DONE
    sb_push(3, 32'hFFFF_FFFF, 1);
    issue(3, DIVU, 32'h0000_1234, 32'd0);
    step_neg();
    check("div0_busy_c1", 64'(bus.o_busy), 64'd1);
    step_neg();
    check("div0_busy_c2", 64'(bus.o_busy), 64'd1);
    step_neg();
    check("div0_busy_c3", 64'(bus.o_busy), 64'd0);
    sb_push(3, 32'd5, 1);
    issue(3, REMU, 32'd5, 32'd0);
    wait_idle(100);

    // Pointer is now 0: cores 0,2,3 together are served 0,2,3
    sb_push(0, 32'h0000_0000, exp_gap(MUL, 32'h0001_0000));
    sb_push(2, 32'h0000_0002, exp_gap(MULHU, 32'd4));
    sb_push(3, 32'hFFFF_FFFF, exp_gap(DIVU, 32'd1));
    issue(0, MUL, 32'h0001_0000, 32'h0001_0000);
    issue(2, MULHU, 32'h8000_0000, 32'd4);
    issue(3, DIVU, 32'hFFFF_FFFF, 32'd1);
    wait_idle(300);

    // Core0 alone moves the pointer to 1, then core1+core0 are served 1,0
    sb_push(0, 32'h0000_000F, exp_gap(REMU, 32'h10));
    issue(0, REMU, 32'hFFFF_FFFF, 32'h10);
    wait_idle(100);
    sb_push(1, 32'hFFFE_0001, exp_gap(MUL, 32'h0000_FFFF));
    sb_push(0, 32'h0000_008E, exp_gap(DIVU, 32'd7));
    issue(1, MUL, 32'h0000_FFFF, 32'h0000_FFFF);
    issue(0, DIVU, 32'd1000, 32'd7);
    wait_idle(200);

    // Core2 aborts in its 10th CALC cycle; queued core3 follows after one IDLE cycle
    sb_push(3, 32'd10, exp_gap(DIVU, 32'd5));
    issue(2, MUL, 32'd5, 32'h8000_0001);
    step_neg();
    issue(3, DIVU, 32'd50, 32'd5);
    repeat (10) step_neg();
    bus.i_req[2] = 1'b0;
    step_neg();
    check("abort_busy", 64'(bus.o_busy), 64'd0);
    check("abort_grant", 64'(bus.o_grant), 64'd0);
    check("abort_result_held", 64'(bus.o_result), 64'h8E);
    step_neg();
    check("abort_next_grant", 64'(bus.o_grant), 64'b1000);
    wait_idle(100);

    // Asynchronous reset in mid-CALC clears outputs at once
    issue(0, MUL, 32'd9, 32'd9);
    repeat (6) step_neg();
    rst_n = 1'b0;
    #1;
    check("midrst_grant", 64'(bus.o_grant), 64'd0);
    check("midrst_busy", 64'(bus.o_busy), 64'd0);
    check("midrst_result", 64'(bus.o_result), 64'd0);
    check("midrst_done", 64'(bus.o_done), 64'd0);
    bus.i_req = '0;
    step_neg();
    rst_n = 1'b1;
    step_neg();
    sb_push(0, 32'h0001_2340, exp_gap(MUL, 32'h10));
    issue(0, MUL, 32'h0000_1234, 32'h10);
    wait_idle(100);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
